// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - pipeline hazard controller stage/status bundle
interface pipeline_ctrl_if;
  logic       decode_valid_in;
  logic [8:0] decode_rs1_in;
  logic [8:0] decode_rs2_in;
  logic       decode_rs1_read_in;
  logic       decode_rs2_read_in;
  logic       execute_valid_in;
  logic       execute_mem_read_in;
  logic [8:0] execute_rd_in;
  logic       mem_valid_in;
  logic       mem_mispredict_in;
  logic       mem_fence_in;
  logic       store_buffer_empty_in;
  logic       dmem_busy_in;
  logic       fetch_stall_out;
  logic       decode_stall_out;
  logic       execute_stall_out;
  logic       mem_stall_out;
  logic       decode_flush_out;
  logic       execute_flush_out;
  logic [1:0] state_out;
  logic [31:0] stall_cycles_out;
  logic [31:0] flush_count_out;

  // pipeline side: drives stage status, receives stall/flush controls
  modport master (
    output decode_valid_in, decode_rs1_in, decode_rs2_in,
           decode_rs1_read_in, decode_rs2_read_in,
           execute_valid_in, execute_mem_read_in, execute_rd_in,
           mem_valid_in, mem_mispredict_in, mem_fence_in,
           store_buffer_empty_in, dmem_busy_in,
    input  fetch_stall_out, decode_stall_out, execute_stall_out, mem_stall_out,
           decode_flush_out, execute_flush_out, state_out,
           stall_cycles_out, flush_count_out
  );

  // controller side
  modport slave (
    input  decode_valid_in, decode_rs1_in, decode_rs2_in,
           decode_rs1_read_in, decode_rs2_read_in,
           execute_valid_in, execute_mem_read_in, execute_rd_in,
           mem_valid_in, mem_mispredict_in, mem_fence_in,
           store_buffer_empty_in, dmem_busy_in,
    output fetch_stall_out, decode_stall_out, execute_stall_out, mem_stall_out,
           decode_flush_out, execute_flush_out, state_out,
           stall_cycles_out, flush_count_out
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - load-use / mispredict / fence / dmem-busy stall and flush controller
module pipeline_ctrl (
  input  logic             clk,
  input  logic             reset,
  pipeline_ctrl_if.slave   bus
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_REDIRECT = 2'd1;
  localparam logic [1:0] ST_FENCE    = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;
  logic        w_load_use;
  logic        w_mispredict;
  logic        w_fence_entry;
  logic [3:0]  w_stall;   // {fetch, decode, execute, mem}
  logic [1:0]  w_flush;   // {decode, execute}

  assign w_load_use = bus.execute_valid_in & bus.execute_mem_read_in & (|bus.execute_rd_in) &
                      bus.decode_valid_in &
                      ((bus.decode_rs1_read_in & (bus.decode_rs1_in == bus.execute_rd_in)) |
                       (bus.decode_rs2_read_in & (bus.decode_rs2_in == bus.execute_rd_in)));

  assign w_mispredict  = bus.mem_valid_in & bus.mem_mispredict_in & ~bus.dmem_busy_in;

  assign w_fence_entry = (r_state == ST_RUN) & bus.mem_valid_in & bus.mem_fence_in &
                         ~bus.store_buffer_empty_in & ~w_mispredict & ~bus.dmem_busy_in;

  // stall/flush decode: reset silences everything, then busy > mispredict > state behaviour
  always_comb begin
    w_stall = 4'b0000;
    w_flush = 2'b00;
    if (reset) begin
      w_stall = 4'b0000;
    end else if (bus.dmem_busy_in) begin
      w_stall = 4'b1111;
    end else if (w_mispredict) begin
      w_flush = 2'b11;
    end else begin
      case (r_state)
        ST_FENCE:    w_stall = bus.store_buffer_empty_in ? 4'b0000 : 4'b1111;
        ST_REDIRECT: w_flush = 2'b10;
        default: begin
          // RUN and the unreachable encoding both behave as RUN
          if (w_load_use) begin
            w_stall = 4'b1100;
            w_flush = 2'b01;
          end
        end
      endcase
    end
  end

  // next-state selection; a busy memory freezes the FSM except for the illegal encoding
  always_comb begin
    w_next_state = ST_RUN;
    if (bus.dmem_busy_in) begin
      w_next_state = (r_state == 2'd3) ? ST_RUN : r_state;
    end else if (w_mispredict) begin
      w_next_state = ST_REDIRECT;
    end else begin
      case (r_state)
        ST_FENCE: w_next_state = bus.store_buffer_empty_in ? ST_RUN : ST_FENCE;
        ST_RUN:   w_next_state = w_fence_entry ? ST_FENCE : ST_RUN;
        default:  w_next_state = ST_RUN;
      endcase
    end
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_next_state;
  end

  // saturating performance counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cycles <= 32'd0;
      r_flush_count  <= 32'd0;
    end else begin
      if ((|w_stall) && (r_stall_cycles != 32'hFFFF_FFFF))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_mispredict && (r_flush_count != 32'hFFFF_FFFF))
        r_flush_count <= r_flush_count + 32'd1;
    end
  end

  assign bus.fetch_stall_out   = w_stall[3];
  assign bus.decode_stall_out  = w_stall[2];
  assign bus.execute_stall_out = w_stall[1];
  assign bus.mem_stall_out     = w_stall[0];
  assign bus.decode_flush_out  = w_flush[1];
  assign bus.execute_flush_out = w_flush[0];
  assign bus.state_out         = reset ? ST_RUN : r_state;
  assign bus.stall_cycles_out  = r_stall_cycles;
  assign bus.flush_count_out   = r_flush_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl against a rule-level model
module tb_pipeline_ctrl;

  typedef struct packed {
    logic       rst;
    logic       dv;
    logic [8:0] rs1;
    logic [8:0] rs2;
    logic       r1;
    logic       r2;
    logic       ev;
    logic       emr;
    logic [8:0] rd;
    logic       mv;
    logic       mmp;
    logic       mf;
    logic       sbe;
    logic       busy;
  } stim_t;

  typedef struct packed {
    logic [3:0]  stall;
    logic [1:0]  flush;
    logic [1:0]  st;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  pipeline_ctrl_if bus ();

  pipeline_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  exp_t   exp_q[$];
  int     total = 0;
  int     bad = 0;

  logic [1:0] m_mode = 2'd0;   // 0 run, 1 redirect, 2 fence, 3 illegal
  longint     m_sc = 0;
  longint     m_fc = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.sbe = 1'b1;
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // apply one cycle of stimulus and queue the response the rules predict for it
  task automatic step(input stim_t s);
    exp_t e;
    bit   lu, mp;
    @(negedge clk);
    reset = s.rst;
    bus.decode_valid_in       = s.dv;
    bus.decode_rs1_in         = s.rs1;
    bus.decode_rs2_in         = s.rs2;
    bus.decode_rs1_read_in    = s.r1;
    bus.decode_rs2_read_in    = s.r2;
    bus.execute_valid_in      = s.ev;
    bus.execute_mem_read_in   = s.emr;
    bus.execute_rd_in         = s.rd;
    bus.mem_valid_in          = s.mv;
    bus.mem_mispredict_in     = s.mmp;
    bus.mem_fence_in          = s.mf;
    bus.store_buffer_empty_in = s.sbe;
    bus.dmem_busy_in          = s.busy;

    lu = s.ev && s.emr && (s.rd != 0) && s.dv &&
         ((s.r1 && s.rs1 == s.rd) || (s.r2 && s.rs2 == s.rd));
    mp = s.mv && s.mmp && !s.busy;
    e = '0;
    if (s.rst) begin
      m_mode = 2'd0;
      m_sc = 0;
      m_fc = 0;
    end else begin
      e.st = m_mode;
      e.sc = m_sc[31:0];
      e.fc = m_fc[31:0];
      if (s.busy)              e.stall = 4'b1111;
      else if (mp)             e.flush = 2'b11;
      else if (m_mode == 2'd2) e.stall = s.sbe ? 4'b0000 : 4'b1111;
      else if (m_mode == 2'd1) e.flush = 2'b10;
      else if (lu) begin
        e.stall = 4'b1100;
        e.flush = 2'b01;
      end
      if (e.stall != 0 && m_sc < 64'hFFFF_FFFF) m_sc++;
      if (mp && m_fc < 64'hFFFF_FFFF) m_fc++;
      if (s.busy)                                   m_mode = (m_mode == 2'd3) ? 2'd0 : m_mode;
      else if (mp)                                  m_mode = 2'd1;
      else if (m_mode == 2'd2)                      m_mode = s.sbe ? 2'd0 : 2'd2;
      else if (m_mode == 2'd0 && s.mv && s.mf && !s.sbe) m_mode = 2'd2;
      else                                          m_mode = 2'd0;
    end
    exp_q.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // monitor: compare the presented outputs of each cycle against the queued prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stalls", {28'd0, bus.fetch_stall_out, bus.decode_stall_out,
                       bus.execute_stall_out, bus.mem_stall_out}, {28'd0, e.stall});
        chk("flushes", {30'd0, bus.decode_flush_out, bus.execute_flush_out}, {30'd0, e.flush});
        chk("state", {30'd0, bus.state_out}, {30'd0, e.st});
        chk("stall_cycles", bus.stall_cycles_out, e.sc);
        chk("flush_count", bus.flush_count_out, e.fc);
      end
    end
  end

  initial begin
    stim_t s;
    // reset held, then released
    s = idle(); s.rst = 1'b1;
    step(s); step(s);
    step(idle());

    // load-use on rs2 for a single cycle
    s = idle(); s.ev = 1; s.emr = 1; s.rd = 9'd5; s.dv = 1; s.rs2 = 9'd5; s.r2 = 1;
    step(s);
    step(idle());
    // rd=0 never hazards
    s.rd = 9'd0; s.rs2 = 9'd0;
    step(s);

    // mispredict alongside a load-use hazard, then redirect, then run
    s = idle(); s.ev = 1; s.emr = 1; s.rd = 9'd7; s.dv = 1; s.rs1 = 9'd7; s.r1 = 1;
    s.mv = 1; s.mmp = 1;
    step(s);
    s.mv = 0; s.mmp = 0;
    step(s);          // redirect suppresses the load-use
    step(idle());

    // fence with pending stores: entry, three held cycles, then drained
    s = idle(); s.mv = 1; s.mf = 1; s.sbe = 0;
    step(s); step(s); step(s); step(s);
    s.sbe = 1;
    step(s);
    step(idle());
    // fence with an already-empty store buffer does nothing
    s = idle(); s.mv = 1; s.mf = 1;
    step(s); step(idle());

    // busy memory during fence with a pending mispredict
    s = idle(); s.mv = 1; s.mf = 1; s.sbe = 0;
    step(s); step(s);
    s.mmp = 1; s.busy = 1;
    repeat (4) step(s);
    s.busy = 0;
    step(s);
    step(idle()); step(idle());

    // stall counter saturation
    after_edge();
    dut.r_stall_cycles = 32'hFFFF_FFFE;
    m_sc = 64'hFFFF_FFFE;
    s = idle(); s.busy = 1;
    repeat (3) step(s);
    step(idle());

    // illegal state encoding falls back to run behaviour
    after_edge();
    dut.r_state = 2'd3;
    m_mode = 2'd3;
    s = idle(); s.ev = 1; s.emr = 1; s.rd = 9'd9; s.dv = 1; s.rs1 = 9'd9; s.r1 = 1;
    step(s);
    step(idle());

    // reset pulse in the middle of a fence
    s = idle(); s.mv = 1; s.mf = 1; s.sbe = 0;
    step(s); step(s);
    s.rst = 1;
    step(s);
    step(idle()); step(idle());

    // randomized traffic over a small register space so hazards are common
    for (int i = 0; i < 400; i++) begin
      s.rst  = ($urandom_range(0, 63) == 0);
      s.dv   = $urandom_range(0, 3) != 0;
      s.rs1  = 9'($urandom_range(0, 3));
      s.rs2  = 9'($urandom_range(0, 3));
      s.r1   = $urandom_range(0, 1);
      s.r2   = $urandom_range(0, 1);
      s.ev   = $urandom_range(0, 3) != 0;
      s.emr  = $urandom_range(0, 1);
      s.rd   = 9'($urandom_range(0, 3));
      s.mv   = $urandom_range(0, 1);
      s.mmp  = ($urandom_range(0, 7) == 0);
      s.mf   = ($urandom_range(0, 5) == 0);
      s.sbe  = $urandom_range(0, 1);
      s.busy = ($urandom_range(0, 5) == 0);
      step(s);
    end
    step(idle());

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #5;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
